// File: rtl/point_addition.sv
// Elliptic-curve affine point addition R = P + Q over GF(p) on y^2 = x^3 + A*x + b.
// One operation per reset release. The datapath uses a shared bit-serial modular multiplier
// and a binary extended-Euclid inverter.
// Optional feature: define POINT_ADD_INF_INPUT_EN to recognise the all-ones x encoding of
// the point at infinity on the inputs.
module point_addition #(
    parameter int n = 10,
    parameter int A = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] p,
    input  logic [n-1:0] x1,
    input  logic [n-1:0] y1,
    input  logic [n-1:0] x2,
    input  logic [n-1:0] y2,
    output logic [n-1:0] x3,
    output logic [n-1:0] y3,
    output logic         result,
    output logic         infinity
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] CHECK      = 3'd1;
    localparam logic [2:0] LAMBDA_NUM = 3'd2;
    localparam logic [2:0] INVERT     = 3'd3;
    localparam logic [2:0] LAMBDA_MUL = 3'd4;
    localparam logic [2:0] X3         = 3'd5;
    localparam logic [2:0] Y3         = 3'd6;
    localparam logic [2:0] DONE       = 3'd7;

    localparam int CW = (n > 1) ? $clog2(n) : 1;
    // Coefficient a is assumed already reduced below p.
    localparam logic [n-1:0] A_N = n'(A);

    function automatic logic [n-1:0] mod_add(input logic [n-1:0] a, input logic [n-1:0] b,
                                              input logic [n-1:0] m);
        logic [n:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[n-1:0];
    endfunction

    function automatic logic [n-1:0] mod_sub(input logic [n-1:0] a, input logic [n-1:0] b,
                                              input logic [n-1:0] m);
        logic [n:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (a < b) d = d + {1'b0, m};
        return d[n-1:0];
    endfunction

    // x/2 mod m for odd m: add m first when x is odd so the shift is exact.
    function automatic logic [n-1:0] mod_half(input logic [n-1:0] x, input logic [n-1:0] m);
        logic [n:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
        return n'(s >> 1);
    endfunction

    logic [2:0]   state;
    logic [1:0]   phase;
    logic [n-1:0] pr, ax1, ay1, ax2, ay2;
    logic [n-1:0] num, den, lam, x3_t, diff;
    logic [n-1:0] u, v, s1, s2;
    logic [n-1:0] mul_a, mul_b, mul_acc;
    logic [CW-1:0] mul_cnt;
    logic         mul_busy;
    logic         mul_go;
    logic [n-1:0] op_a, op_b;
    logic         p_inf, q_inf;

`ifdef POINT_ADD_INF_INPUT_EN
    assign p_inf = (ax1 == '1);
    assign q_inf = (ax2 == '1);
`else
    assign p_inf = 1'b0;
    assign q_inf = 1'b0;
`endif

    // Decode when the FSM launches a product and which operands it uses.
    always_comb begin
        mul_go = 1'b0;
        op_a   = lam;
        op_b   = lam;
        case (state)
            LAMBDA_NUM: if (phase == 2'd0 && ax1 == ax2) begin
                mul_go = 1'b1;
                op_a   = ax1;
                op_b   = ax1;
            end
            LAMBDA_MUL: if (phase == 2'd0) begin
                mul_go = 1'b1;
                op_a   = num;
                op_b   = den;
            end
            X3: mul_go = (phase == 2'd0);
            Y3: if (phase == 2'd1) begin
                mul_go = 1'b1;
                op_b   = diff;
            end
            default: ;
        endcase
    end

    // MSB-first interleaved multiplier: acc = 2*acc (+a) mod p, one bit of b per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_a    <= '0;
            mul_b    <= '0;
            mul_acc  <= '0;
            mul_cnt  <= '0;
            mul_busy <= 1'b0;
        end else if (mul_go) begin
            mul_a    <= op_a;
            mul_b    <= op_b;
            mul_acc  <= '0;
            mul_cnt  <= CW'(n - 1);
            mul_busy <= 1'b1;
        end else if (mul_busy) begin
            mul_acc <= mul_b[mul_cnt] ? mod_add(mod_add(mul_acc, mul_acc, pr), mul_a, pr)
                                      : mod_add(mul_acc, mul_acc, pr);
            if (mul_cnt == '0) mul_busy <= 1'b0;
            else mul_cnt <= mul_cnt - 1'b1;
        end
    end

    // Sequencing FSM plus the single-cycle add/sub/inverse datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            phase    <= '0;
            pr       <= '0;
            ax1      <= '0;
            ay1      <= '0;
            ax2      <= '0;
            ay2      <= '0;
            num      <= '0;
            den      <= '0;
            lam      <= '0;
            x3_t     <= '0;
            diff     <= '0;
            u        <= '0;
            v        <= '0;
            s1       <= '0;
            s2       <= '0;
            x3       <= '0;
            y3       <= '0;
            result   <= 1'b0;
            infinity <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pr    <= p;
                    ax1   <= x1;
                    ay1   <= y1;
                    ax2   <= x2;
                    ay2   <= y2;
                    phase <= '0;
                    state <= CHECK;
                end
                CHECK: begin
                    if ((p_inf && q_inf) ||
                        (ax1 == ax2 && (ay1 != ay2 || ay1 == '0))) begin
                        x3       <= '1;
                        y3       <= '1;
                        infinity <= 1'b1;
                        state    <= DONE;
                    end else if (p_inf) begin
                        x3     <= ax2;
                        y3     <= ay2;
                        result <= 1'b1;
                        state  <= DONE;
                    end else if (q_inf) begin
                        x3     <= ax1;
                        y3     <= ay1;
                        result <= 1'b1;
                        state  <= DONE;
                    end else begin
                        state <= LAMBDA_NUM;
                    end
                end
                LAMBDA_NUM: begin
                    if (ax1 != ax2) begin
                        num   <= mod_sub(ay2, ay1, pr);
                        den   <= mod_sub(ax2, ax1, pr);
                        state <= INVERT;
                    end else begin
                        // Doubling: num = 3*x1^2 + A built from x1^2 with three mod adds.
                        case (phase)
                            2'd0: begin
                                den   <= mod_add(ay1, ay1, pr);
                                phase <= 2'd1;
                            end
                            2'd1: if (!mul_busy) begin
                                num   <= mod_add(mul_acc, mul_acc, pr);
                                phase <= 2'd2;
                            end
                            2'd2: begin
                                num   <= mod_add(num, mul_acc, pr);
                                phase <= 2'd3;
                            end
                            default: begin
                                num   <= mod_add(num, A_N, pr);
                                phase <= 2'd0;
                                state <= INVERT;
                            end
                        endcase
                    end
                end
                INVERT: begin
                    // Invariants: s1*den = u, s2*den = v (mod p). The inverse replaces den.
                    if (phase == 2'd0) begin
                        u     <= den;
                        v     <= pr;
                        s1    <= n'(1);
                        s2    <= '0;
                        phase <= 2'd1;
                    end else if (u == n'(1) || v == n'(1)) begin
                        den   <= (u == n'(1)) ? s1 : s2;
                        phase <= 2'd0;
                        state <= LAMBDA_MUL;
                    end else if (!u[0]) begin
                        u  <= u >> 1;
                        s1 <= mod_half(s1, pr);
                    end else if (!v[0]) begin
                        v  <= v >> 1;
                        s2 <= mod_half(s2, pr);
                    end else if (u >= v) begin
                        u  <= (u - v) >> 1;
                        s1 <= mod_half(mod_sub(s1, s2, pr), pr);
                    end else begin
                        v  <= (v - u) >> 1;
                        s2 <= mod_half(mod_sub(s2, s1, pr), pr);
                    end
                end
                LAMBDA_MUL: begin
                    if (phase == 2'd0) begin
                        phase <= 2'd1;
                    end else if (!mul_busy) begin
                        lam   <= mul_acc;
                        phase <= 2'd0;
                        state <= X3;
                    end
                end
                X3: begin
                    case (phase)
                        2'd0: phase <= 2'd1;
                        2'd1: if (!mul_busy) begin
                            x3_t  <= mod_sub(mul_acc, ax1, pr);
                            phase <= 2'd2;
                        end
                        default: begin
                            x3_t  <= mod_sub(x3_t, ax2, pr);
                            phase <= 2'd0;
                            state <= Y3;
                        end
                    endcase
                end
                Y3: begin
                    case (phase)
                        2'd0: begin
                            diff  <= mod_sub(ax1, x3_t, pr);
                            phase <= 2'd1;
                        end
                        2'd1: phase <= 2'd2;
                        default: if (!mul_busy) begin
                            x3     <= x3_t;
                            y3     <= mod_sub(mul_acc, ay1, pr);
                            result <= 1'b1;
                            state  <= DONE;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_point_addition.sv
// Directed bench for point_addition with p = 17, A = 2 (curve b = 2).
// Expected points were computed by hand on y^2 = x^3 + 2x + 2 mod 17.
module tb_point_addition;

    localparam int N = 10;
    localparam int MAX_LAT = 12 * N + 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] p = 10'd17;
    logic [N-1:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0;
    logic [N-1:0] x3, y3;
    logic         result, infinity;

    int checks = 0;
    int errors = 0;

    point_addition #(.n(N), .A(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .p        (p),
        .x1       (x1),
        .y1       (y1),
        .x2       (x2),
        .y2       (y2),
        .x3       (x3),
        .y3       (y3),
        .result   (result),
        .infinity (infinity)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply operands under reset, release, wait for completion within the latency bound.
    task automatic run_case(input string tag, input logic [N-1:0] ix1, input logic [N-1:0] iy1,
                            input logic [N-1:0] ix2, input logic [N-1:0] iy2,
                            input logic exp_inf, input logic [N-1:0] ex3,
                            input logic [N-1:0] ey3);
        int cyc;
        bit done;
        @(negedge clk);
        reset = 1'b1;
        x1 = ix1;
        y1 = iy1;
        x2 = ix2;
        y2 = iy2;
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < MAX_LAT + 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (result || infinity) done = 1'b1;
        end
        check({tag, "_lat"}, 32'(done && (cyc - 1) <= MAX_LAT), 32'd1);
        check({tag, "_result"}, 32'(result), 32'(!exp_inf));
        check({tag, "_inf"}, 32'(infinity), 32'(exp_inf));
        check({tag, "_x3"}, 32'(x3), 32'(ex3));
        check({tag, "_y3"}, 32'(y3), 32'(ey3));
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_hold"}, {30'd0, result, infinity}, {30'd0, !exp_inf, exp_inf});
        check({tag, "_hold_xy"}, {12'd0, x3, y3}, {12'd0, ex3, ey3});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_x3", 32'(x3), 32'd0);
        check("rst_y3", 32'(y3), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_inf", 32'(infinity), 32'd0);

        run_case("add", 10'd5, 10'd1, 10'd6, 10'd3, 1'b0, 10'd10, 10'd6);
        run_case("add_swap", 10'd6, 10'd3, 10'd5, 10'd1, 1'b0, 10'd10, 10'd6);
        run_case("dbl", 10'd5, 10'd1, 10'd5, 10'd1, 1'b0, 10'd6, 10'd3);
        run_case("dbl2", 10'd10, 10'd6, 10'd10, 10'd6, 1'b0, 10'd16, 10'd13);
        run_case("add2", 10'd5, 10'd1, 10'd10, 10'd6, 1'b0, 10'd3, 10'd1);
        run_case("neg", 10'd5, 10'd1, 10'd5, 10'd16, 1'b1, 10'd1023, 10'd1023);
        run_case("dbl_y0", 10'd4, 10'd0, 10'd4, 10'd0, 1'b1, 10'd1023, 10'd1023);
`ifdef POINT_ADD_INF_INPUT_EN
        run_case("p_inf", 10'd1023, 10'd0, 10'd3, 10'd1, 1'b0, 10'd3, 10'd1);
        run_case("q_inf", 10'd6, 10'd3, 10'd1023, 10'd5, 1'b0, 10'd6, 10'd3);
        run_case("both_inf", 10'd1023, 10'd0, 10'd1023, 10'd0, 1'b1, 10'd1023, 10'd1023);
`endif

        // Abort an addition part-way with an asynchronous reset, then rerun it.
        @(negedge clk);
        reset = 1'b1;
        x1 = 10'd5;
        y1 = 10'd1;
        x2 = 10'd6;
        y2 = 10'd3;
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("mid_not_done", {30'd0, result, infinity}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_x3", 32'(x3), 32'd0);
        check("mid_rst_y3", 32'(y3), 32'd0);
        check("mid_rst_flags", {30'd0, result, infinity}, 32'd0);
        run_case("after_rst", 10'd5, 10'd1, 10'd6, 10'd3, 1'b0, 10'd10, 10'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
